// File: rtl/reg_file_alu_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_alu_pkg
//   Shared types for the register-file / ALU datapath.
//   - alu_op_e    : 3-bit ALU operation encoding
//   - alu_flags_t : packed result flags {zero, carry, neg, ovf}
//   - helpers     : operation-field width, flag reset value, shift-amount width
// -----------------------------------------------------------------------------
package reg_file_alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '0;

  // Number of low B bits used as the shift amount.
  function automatic int unsigned shamt_width(input int unsigned data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/reg_file_alu_pipe_alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
//   Purely combinational 8-operation ALU, arithmetic modulo 2^DATA_W.
//   Ports:
//     i_a      [DATA_W-1:0]  operand A
//     i_b      [DATA_W-1:0]  operand B
//     i_op     alu_op_e      operation select
//     o_result [DATA_W-1:0]  result
//     o_flags  alu_flags_t   {zero, carry, neg, ovf}
//   carry is the carry-out for ADD and NOT-borrow for SUB/SLT (A + ~B + 1);
//   ovf is signed overflow for ADD/SUB only.
// -----------------------------------------------------------------------------
module alu_unit
  import reg_file_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_e           i_op,
  output logic [DATA_W-1:0] o_result,
  output alu_flags_t        o_flags
);

  localparam int unsigned SH_W = shamt_width(DATA_W);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [SH_W-1:0]   w_shamt;
  logic              w_lt;
  logic [DATA_W-1:0] w_res;
  logic              w_carry;
  logic              w_ovf;

  assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff  = {1'b0, i_a} + {1'b0, ~i_b} + {{DATA_W{1'b0}}, 1'b1};
  assign w_shamt = i_b[SH_W-1:0];
  assign w_lt    = ($signed(i_a) < $signed(i_b));

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (i_op)
      ALU_ADD: begin
        w_res   = w_sum[DATA_W-1:0];
        w_carry = w_sum[DATA_W];
        // Same-sign operands producing a different-sign result.
        w_ovf   = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                  (w_sum[DATA_W-1] != i_a[DATA_W-1]);
      end
      ALU_SUB: begin
        w_res   = w_diff[DATA_W-1:0];
        w_carry = w_diff[DATA_W];
        // Opposite-sign operands where the result sign differs from A.
        w_ovf   = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                  (w_diff[DATA_W-1] != i_a[DATA_W-1]);
      end
      ALU_AND: w_res = i_a & i_b;
      ALU_OR:  w_res = i_a | i_b;
      ALU_XOR: w_res = i_a ^ i_b;
      ALU_SHL: w_res = i_a << w_shamt;
      ALU_SHR: w_res = i_a >> w_shamt;
      ALU_SLT: begin
        w_res[0] = w_lt;
        w_carry  = w_diff[DATA_W];
      end
      default: w_res = '0;
    endcase
  end

  assign o_result      = w_res;
  assign o_flags.zero  = (w_res == '0);
  assign o_flags.carry = w_carry;
  assign o_flags.neg   = w_res[DATA_W-1];
  assign o_flags.ovf   = w_ovf;

endmodule

// File: rtl/reg_file_alu_pipe.sv
// -----------------------------------------------------------------------------
// reg_file_alu_pipe
//   NREGS x DATA_W register file (2 read / 1 write) feeding alu_unit, with a
//   registered execute (EX) stage, write-back and bypass forwarding.
//   Ports:
//     clk, rst_n             clock (rising edge), async active-low reset
//     in_valid               operation presented this cycle
//     ra1, ra2               read addresses for operand A / register operand B
//     wa, we                 write-back address / enable (qualified by in_valid)
//     alu_src                1: B = imm, 0: B = register ra2
//     alu_op                 alu_op_e encoding
//     imm                    immediate operand
//     out_valid              outputs carry a new result (latency 1)
//     alu_result, cpu_out    registered ALU result and operand A
//     zero, carry, neg, ovf  registered flags
//   The EX result is written into the file at the end of the cycle in which
//   it is presented; reads in that same cycle are bypassed from EX, so the
//   pipeline behaves as if each operation wrote back immediately.
// -----------------------------------------------------------------------------
module reg_file_alu_pipe
  import reg_file_alu_pkg::*;
#(
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned NREGS   = 16,
  parameter  bit          R0_ZERO = 1'b1,
  localparam int unsigned ADDR_W  = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  input  logic [ADDR_W-1:0]   wa,
  input  logic                we,
  input  logic                alu_src,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   imm,
  output logic                out_valid,
  output logic [DATA_W-1:0]   alu_result,
  output logic [DATA_W-1:0]   cpu_out,
  output logic                zero,
  output logic                carry,
  output logic                neg,
  output logic                ovf
);

  // Architectural state
  logic [DATA_W-1:0] r_regs [NREGS];

  // EX stage
  logic              r_out_valid;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_cpu_out;
  alu_flags_t        r_flags;
  logic [ADDR_W-1:0] r_ex_wa;
  logic              r_ex_we;

  // Read / execute datapath
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_res;
  alu_flags_t        w_flags;
  logic              w_wa_is_r0;
  logic              w_ra1_is_r0;
  logic              w_ra2_is_r0;

  assign w_wa_is_r0  = R0_ZERO && (wa  == '0);
  assign w_ra1_is_r0 = R0_ZERO && (ra1 == '0);
  assign w_ra2_is_r0 = R0_ZERO && (ra2 == '0);

  // Bypass: a pending EX write to the read address wins over the file.
  // r_ex_we is never set for a hardwired-zero R0, so R0 is never forwarded.
  always_comb begin
    w_rd1 = r_regs[ra1];
    if (r_ex_we && (r_ex_wa == ra1)) begin
      w_rd1 = r_alu_result;
    end
    if (w_ra1_is_r0) begin
      w_rd1 = '0;
    end
  end

  always_comb begin
    w_rd2 = r_regs[ra2];
    if (r_ex_we && (r_ex_wa == ra2)) begin
      w_rd2 = r_alu_result;
    end
    if (w_ra2_is_r0) begin
      w_rd2 = '0;
    end
  end

  assign w_b = alu_src ? imm : w_rd2;

  alu_unit #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a      (w_rd1),
    .i_b      (w_b),
    .i_op     (alu_op_e'(alu_op)),
    .o_result (w_res),
    .o_flags  (w_flags)
  );

  // Register file write-back from EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '{default: '0};
    end else if (r_ex_we) begin
      r_regs[r_ex_wa] <= r_alu_result;
    end
  end

  // EX pipeline register. Writes to a hardwired-zero R0 are dropped here so
  // the result is still reported but never reaches state or the bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_alu_result <= '0;
      r_cpu_out    <= '0;
      r_flags      <= FLAGS_CLEAR;
      r_ex_wa      <= '0;
      r_ex_we      <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_ex_we     <= in_valid & we & ~w_wa_is_r0;
      if (in_valid) begin
        r_alu_result <= w_res;
        r_cpu_out    <= w_rd1;
        r_flags      <= w_flags;
        r_ex_wa      <= wa;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_result = r_alu_result;
  assign cpu_out    = r_cpu_out;
  assign zero       = r_flags.zero;
  assign carry      = r_flags.carry;
  assign neg        = r_flags.neg;
  assign ovf        = r_flags.ovf;

endmodule

// File: tb/tb_reg_file_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_reg_file_alu_pipe
//   Self-checking bench for reg_file_alu_pipe (DATA_W=8, NREGS=16). A second
//   instance with R0_ZERO=0 shares the inputs to show R0 is writable there.
// -----------------------------------------------------------------------------
module tb_reg_file_alu_pipe;

  localparam int NR = 16;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] ra1, ra2, wa;
  logic       we, alu_src;
  logic [2:0] alu_op;
  logic [7:0] imm;

  logic       out_valid, zero, carry, neg, ovf;
  logic [7:0] alu_result, cpu_out;
  logic       d2_out_valid, d2_zero, d2_carry, d2_neg, d2_ovf;
  logic [7:0] d2_alu_result, d2_cpu_out;

  int total = 0;
  int bad   = 0;

  reg_file_alu_pipe #(.DATA_W(8), .NREGS(16), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ra1(ra1), .ra2(ra2),
    .wa(wa), .we(we), .alu_src(alu_src), .alu_op(alu_op), .imm(imm),
    .out_valid(out_valid), .alu_result(alu_result), .cpu_out(cpu_out),
    .zero(zero), .carry(carry), .neg(neg), .ovf(ovf)
  );

  reg_file_alu_pipe #(.DATA_W(8), .NREGS(16), .R0_ZERO(1'b0)) dut_r0w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ra1(ra1), .ra2(ra2),
    .wa(wa), .we(we), .alu_src(alu_src), .alu_op(alu_op), .imm(imm),
    .out_valid(d2_out_valid), .alu_result(d2_alu_result), .cpu_out(d2_cpu_out),
    .zero(d2_zero), .carry(d2_carry), .neg(d2_neg), .ovf(d2_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (sequential ISA semantics) -------------
  int         mregs [NR];
  logic       m_v;
  int         m_res, m_a;
  logic [3:0] m_fl;   // {zero, carry, neg, ovf}

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int res, output logic [3:0] fl);
    int sa, sb;
    logic c, o;
    sa = to_signed8(a);
    sb = to_signed8(b);
    c = 1'b0;
    o = 1'b0;
    res = 0;
    case (op)
      0: begin res = (a + b) % 256; c = (a + b) > 255;
               o = ((sa + sb) > 127) || ((sa + sb) < -128); end
      1: begin res = (a - b + 256) % 256; c = (a >= b);
               o = ((sa - sb) > 127) || ((sa - sb) < -128); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (a << (b % 8)) % 256;
      6: res = a >> (b % 8);
      7: begin res = (sa < sb) ? 1 : 0; c = (a >= b); end
      default: res = 0;
    endcase
    fl = {res == 0, c, res >= 128, o};
  endfunction

  task automatic model_reset();
    foreach (mregs[i]) mregs[i] = 0;
    m_v = 1'b0; m_res = 0; m_a = 0; m_fl = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Present one operation for one cycle; outputs are sampled 1 time unit
  // after the rising edge. The model applies the op and its write at once.
  task automatic issue(input logic v, input int a1, input int a2, input int w,
                       input logic we_i, input logic src, input int op, input int im);
    int a, b, res;
    logic [3:0] fl;
    logic [31:0] t;
    in_valid = v;
    t = a1; ra1 = t[3:0];
    t = a2; ra2 = t[3:0];
    t = w;  wa  = t[3:0];
    we = we_i;
    alu_src = src;
    t = op; alu_op = t[2:0];
    t = im; imm = t[7:0];
    a = (a1 == 0) ? 0 : mregs[a1];
    b = src ? im : ((a2 == 0) ? 0 : mregs[a2]);
    @(posedge clk);
    #1;
    m_v = v;
    if (v) begin
      ref_alu(a, b, op, res, fl);
      m_res = res;
      m_a   = a;
      m_fl  = fl;
      if (we_i && (w != 0)) mregs[w] = res;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " out_valid"}, out_valid, m_v);
    chk({tag, " alu_result"}, alu_result, m_res);
    chk({tag, " cpu_out"}, cpu_out, m_a);
    chk({tag, " flags"}, {zero, carry, neg, ovf}, m_fl);
  endtask

  // ---------------- directed vector table -----------------------------------
  typedef struct {
    int a1, a2, w;
    logic we, src;
    int op, im;
    int er, ea;
    logic [3:0] ef;   // {zero, carry, neg, ovf}
  } vec_t;

  vec_t tbl [18];

  initial begin
    // loads, op sweep on A=0x96 B=3 (r2 forwarded), flag corners, bypass
    tbl[0]  = '{0, 0, 1, 1, 1, 0, 'h96, 'h96, 'h00, 4'b0010};
    tbl[1]  = '{0, 0, 2, 1, 1, 0, 3,    3,    'h00, 4'b0000};
    tbl[2]  = '{1, 2, 0, 0, 0, 5, 0,    'hB0, 'h96, 4'b0010};
    tbl[3]  = '{1, 2, 0, 0, 0, 6, 0,    'h12, 'h96, 4'b0000};
    tbl[4]  = '{1, 2, 0, 0, 0, 2, 0,    'h02, 'h96, 4'b0000};
    tbl[5]  = '{1, 2, 0, 0, 0, 3, 0,    'h97, 'h96, 4'b0010};
    tbl[6]  = '{1, 2, 0, 0, 0, 4, 0,    'h95, 'h96, 4'b0010};
    tbl[7]  = '{1, 2, 0, 0, 0, 7, 0,    1,    'h96, 4'b0100};
    tbl[8]  = '{1, 2, 0, 0, 0, 0, 0,    'h99, 'h96, 4'b0010};
    tbl[9]  = '{1, 1, 0, 0, 0, 1, 0,    0,    'h96, 4'b1100};
    tbl[10] = '{0, 0, 3, 1, 1, 0, 'h7F, 'h7F, 'h00, 4'b0000};
    tbl[11] = '{3, 0, 0, 0, 1, 0, 1,    'h80, 'h7F, 4'b0011};
    tbl[12] = '{0, 0, 4, 1, 1, 0, 'hFF, 'hFF, 'h00, 4'b0010};
    tbl[13] = '{4, 0, 0, 0, 1, 0, 1,    0,    'hFF, 4'b1100};
    tbl[14] = '{2, 0, 0, 0, 1, 1, 5,    'hFE, 3,    4'b0010};
    tbl[15] = '{2, 0, 0, 0, 1, 7, 'h96, 0,    3,    4'b1000};
    tbl[16] = '{1, 1, 5, 1, 0, 0, 0,    'h2C, 'h96, 4'b0101};
    tbl[17] = '{5, 5, 0, 0, 0, 4, 0,    0,    'h2C, 4'b1000};

    in_valid = 1'b0; ra1 = '0; ra2 = '0; wa = '0; we = 1'b0;
    alu_src = 1'b0; alu_op = '0; imm = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset alu_result", alu_result, 0);
    chk("reset cpu_out", cpu_out, 0);
    chk("reset flags", {zero, carry, neg, ovf}, 0);
    chk("reset out_valid", out_valid, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      issue(1'b1, tbl[i].a1, tbl[i].a2, tbl[i].w, tbl[i].we, tbl[i].src, tbl[i].op, tbl[i].im);
      chk($sformatf("vec%0d result", i), alu_result, tbl[i].er);
      chk($sformatf("vec%0d cpu_out", i), cpu_out, tbl[i].ea);
      chk($sformatf("vec%0d flags", i), {zero, carry, neg, ovf}, tbl[i].ef);
      chk($sformatf("vec%0d out_valid", i), out_valid, 1);
    end

    // Idle with we=1: no capture, outputs hold, r1 untouched.
    issue(1'b0, 1, 0, 1, 1'b1, 1'b1, 0, 'h55);
    chk("idle out_valid", out_valid, 0);
    chk("idle hold cpu_out", cpu_out, 'h2C);
    chk("idle hold flags", {zero, carry, neg, ovf}, 4'b1000);
    issue(1'b1, 1, 0, 0, 1'b0, 1'b1, 0, 0);
    chk("idle r1 unchanged", alu_result, 'h96);

    // R0 write: result produced, state unchanged unless R0 is writable.
    issue(1'b1, 0, 0, 0, 1'b1, 1'b1, 0, 15);
    chk("r0 write result", alu_result, 15);
    chk("r0 write out_valid", out_valid, 1);
    issue(1'b1, 0, 0, 0, 1'b0, 1'b1, 0, 0);
    chk("r0 reads zero", alu_result, 0);
    chk("r0 writable build", d2_alu_result, 15);

    // Reset mid-stream with a write-back still pending.
    issue(1'b1, 0, 0, 1, 1'b1, 1'b1, 0, 'h11);
    issue(1'b1, 0, 0, 2, 1'b1, 1'b1, 0, 'h22);
    issue(1'b1, 0, 0, 3, 1'b1, 1'b1, 0, 'h33);
    chk("pre-reset result", alu_result, 'h33);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset alu_result", alu_result, 0);
    chk("async reset cpu_out", cpu_out, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      issue(1'b1, r, 0, 0, 1'b0, 1'b1, 0, 0);
      chk($sformatf("post-reset r%0d", r), alu_result, 0);
      chk($sformatf("post-reset r%0d cpu_out", r), cpu_out, 0);
    end

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 255));
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
